// File: rtl/sbox_gen.sv
// Chaotic-map driven S-box generator.
// Emits a 256-byte permutation derived from a seeded logistic-style map.
module sbox_gen #(
  parameter int WARMUP = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        cfg_err,
  output logic [7:0]  sbox_out,
  output logic        sbox_valid,
  output logic [7:0]  sbox_idx,
  output logic        sbox_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_ITER,
    S_PROBE,
    S_DONE
  } state_t;

  localparam logic [9:0] WLAST =
    10'((WARMUP == 0) ? 0 : WARMUP - 1);

  state_t       state_q, state_d;
  logic [31:0]  x_q, x_d;
  logic [255:0] used_q, used_d;
  logic [8:0]   cnt_q, cnt_d;
  logic [7:0]   p_q, p_d;
  logic [9:0]   wcnt_q, wcnt_d;
  logic [7:0]   out_q, out_d;
  logic [7:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         cerr_q, cerr_d;

  logic [31:0]  xn;
  logic [7:0]   cand;
  logic         emit;
  logic [7:0]   eb;

  function automatic logic [31:0] map_step(
    input logic [31:0] x
  );
    logic [63:0] prod;
    logic [31:0] r;
    prod = {32'd0, x} *
           (64'h1_0000_0000 - {32'd0, x});
    r = 32'(prod >> 30);
    if (r == 32'd0) r = 32'h9E37_79B9;
    return r;
  endfunction

  assign xn   = map_step(x_q);
  assign cand = xn[31:24] ^ xn[7:0];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      used_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      wcnt_q  <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      used_q  <= used_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      wcnt_q  <= wcnt_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cerr_q  <= cerr_d;
    end
  end

  // Next-state: warm-up, candidate draw, linear probe, emit.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    used_d  = used_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    wcnt_d  = wcnt_q;
    out_d   = out_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    cerr_d  = 1'b0;
    emit    = 1'b0;
    eb      = 8'd0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (seed == 32'd0) begin
            cerr_d = 1'b1;
          end else begin
            x_d     = seed;
            used_d  = '0;
            cnt_d   = '0;
            wcnt_d  = '0;
            state_d = (WARMUP == 0) ?
                      S_ITER : S_WARMUP;
          end
        end
      end
      S_WARMUP: begin
        x_d    = xn;
        wcnt_d = wcnt_q + 10'd1;
        if (wcnt_q == WLAST) state_d = S_ITER;
      end
      S_ITER: begin
        x_d = xn;
        if (!used_q[cand]) begin
          emit = 1'b1;
          eb   = cand;
        end else begin
          p_d     = cand + 8'd1;
          state_d = S_PROBE;
        end
      end
      S_PROBE: begin
        if (!used_q[p_q]) begin
          emit    = 1'b1;
          eb      = p_q;
          state_d = S_ITER;
        end else begin
          p_d = p_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (emit) begin
      out_d      = eb;
      idx_d      = cnt_q[7:0];
      valid_d    = 1'b1;
      last_d     = (cnt_q == 9'd255);
      used_d[eb] = 1'b1;
      cnt_d      = cnt_q + 9'd1;
      if (cnt_q == 9'd255) state_d = S_DONE;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign cfg_err    = cerr_q;
  assign sbox_out   = out_q;
  assign sbox_valid = valid_q;
  assign sbox_idx   = idx_q;
  assign sbox_last  = last_q;

endmodule

// File: doc/sbox_gen.md
SBOX_GEN -- requirements
Module: sbox_gen

Interface
REQ-001 The block SHALL have parameter WARMUP, default 64, meaning the number of chaotic-map iterations discarded after start before any byte is emitted (range 0..1023).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, single-cycle request to generate a new S-box.
REQ-005 The block SHALL have port seed, input, 32, Q0.32 initial value of the chaotic map, sampled on an accepted start.
REQ-006 The block SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-007 The block SHALL have port done, output, 1, one-cycle pulse after the 256th byte has been emitted.
REQ-008 The block SHALL have port cfg_err, output, 1, one-cycle pulse when a start is rejected because seed is zero.
REQ-009 The block SHALL have port sbox_out, output, 8, the S-box byte for the current index; it drives the downstream F stage directly.
REQ-010 The block SHALL have port sbox_valid, output, 1, high for exactly one cycle per emitted byte.
REQ-011 The block SHALL have port sbox_idx, output, 8, the table index of sbox_out, in order 0,1,...,255.
REQ-012 The block SHALL have port sbox_last, output, 1, high together with sbox_valid for index 255 only.

Function
REQ-013 The block SHALL implement the FSM states IDLE, WARMUP, ITER, PROBE and DONE.
REQ-014 In IDLE, start with seed!=0 SHALL do the following on the next edge: load x<=seed, clear the 256-bit used mask and the 9-bit emit count, then enter WARMUP (or ITER if WARMUP==0).
REQ-015 In IDLE, start with seed==0 SHALL pulse cfg_err on the next cycle and leave the block in IDLE.
REQ-016 Start received outside IDLE SHALL be ignored, with no effect on state or outputs.
REQ-017 Map step, in all arithmetic: x_next = (x * (2^32 - x)) >> 30, truncated to 32 bits, using a 64-bit unsigned product; if x_next==0, x_next SHALL be replaced by 32'h9E3779B9.
REQ-018 WARMUP SHALL apply one map step per cycle for exactly WARMUP cycles and emit nothing, then enter ITER.
REQ-019 ITER SHALL apply one map step per cycle; candidate c = x_next[31:24] XOR x_next[7:0].
REQ-020 If used[c]==0, the block SHALL, on the next cycle, present sbox_out=c, sbox_valid=1 and sbox_idx=count; it SHALL also set used[c] and increment count.
REQ-021 If used[c]==1, the block SHALL enter PROBE with p=c+1 mod 256; the map SHALL NOT step while in PROBE.
REQ-022 PROBE SHALL test one p per cycle; if used[p]==0, the block SHALL emit p per REQ-020 and return to ITER, otherwise p<=p+1 mod 256 (wrap 255->0).
REQ-023 After the emit with count==255 (sbox_last=1), the block SHALL enter DONE; DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-024 Emitted bytes SHALL form a permutation of 0..255, with exactly 256 sbox_valid pulses per run.
REQ-025 sbox_out and sbox_idx SHALL hold their last emitted value when sbox_valid==0.
REQ-026 The output stream SHALL be a pure function of seed and WARMUP.
REQ-027 Latency: the first sbox_valid SHALL occur no earlier than WARMUP+2 cycles after start; PROBE SHALL be bounded to 255 cycles per byte.

Reset
REQ-028 While reset_n==0 at a clock edge, the block SHALL force: state=IDLE, x=0, used=0, count=0, p=0, busy=0, done=0, cfg_err=0, sbox_valid=0, sbox_last=0, sbox_out=0, sbox_idx=0.
REQ-029 Reset asserted mid-run SHALL abort the run with no further sbox_valid; a new start SHALL be required afterwards.

Verification
REQ-030 Basic run: reset 10 cycles, start with seed=32'h3C6EF372, WARMUP=64 -> exactly 256 sbox_valid pulses, sbox_idx 0..255 in order, sbox_last only on idx 255, then done pulse, busy low afterwards.
REQ-031 Bijectivity: after the basic run, the 256 collected bytes -> every value 0..255 appears exactly once; bytes match a software model of REQ-017..022.
REQ-032 Determinism: repeat the run with the same seed -> an identical stream; a run with seed=32'h3C6EF373 -> a stream that differs.
REQ-033 Zero seed: start with seed=0 -> cfg_err pulse one cycle later, busy stays 0, no sbox_valid.
REQ-034 Start while busy: assert start at byte 100 -> ignored, with the stream identical to the basic run.
REQ-035 Mid-run reset: drop reset_n for 2 cycles at byte 50 -> all outputs 0, no further valid; a new start with the basic seed -> an identical full stream.
